turf_ram_scheduler: RTL and testbench

- Sequences the single-port paint RAM (15-bit address {x[7:0], y[6:0]}, 3-bit colour) across a full game: clear, paint, tally.
- Clears the arena, then writes each player's colour at their position on every move tick for a fixed number of ticks.
- Then scans the arena once, counts pixels per colour and declares the winner.
- Sits between the player movement/direction logic and the RAM; the RAM has no other writer.

---
 rtl/turf_ram_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_turf_ram_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/turf_ram_scheduler.sv
// Paint-RAM sequencer: clear arena, paint four players per move tick, then tally pixels and pick a winner.
// Tally reaches done N+1 cycles after entry (N = arena size); build with TURF_PAUSE_EN to add a pause input that freezes RUN.
module turf_ram_scheduler #(
   parameter int GAME_TICKS = 600,
   parameter int X_MAX      = 158,
   parameter int Y_MAX      = 119,
   parameter int COUNT_W    = 15
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               start,
`ifdef TURF_PAUSE_EN
   input  logic               pause,
`endif
   input  logic               move_tick,
   input  logic [14:0]        p1,
   input  logic [14:0]        p2,
   input  logic [14:0]        p3,
   input  logic [14:0]        p4,
   input  logic [2:0]         ram_q,
   output logic               ram_wren,
   output logic [14:0]        ram_address,
   output logic [2:0]         ram_data,
   output logic               running,
   output logic               done,
   output logic [COUNT_W-1:0] p1_count,
   output logic [COUNT_W-1:0] p2_count,
   output logic [COUNT_W-1:0] p3_count,
   output logic [COUNT_W-1:0] p4_count,
   output logic [1:0]         winner
);

   localparam int         TICK_W = $clog2(GAME_TICKS + 1);
   localparam logic [7:0] X_LAST = 8'(X_MAX);
   localparam logic [6:0] Y_LAST = 7'(Y_MAX);

   typedef enum logic [3:0] {
      IDLE, CLEAR, RUN, PAINT_P1, PAINT_P2, PAINT_P3, PAINT_P4, TALLY, DRAIN, DONE
   } state_t;

   state_t              state, state_nxt;
   logic [7:0]          scan_x;
   logic [6:0]          scan_y;
   logic [TICK_W-1:0]   tick_cnt;
   logic                rd_vld;
   logic                scan_last;
   logic                tick_go;
   logic [COUNT_W-1:0]  cnt     [4];
   logic [COUNT_W-1:0]  cnt_nxt [4];
   logic [COUNT_W-1:0]  best_cnt;
   logic [1:0]          win_nxt;

`ifdef TURF_PAUSE_EN
   assign tick_go = move_tick & ~pause;
`else
   assign tick_go = move_tick;
`endif

   assign scan_last = (scan_x == X_LAST) && (scan_y == Y_LAST);

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      ram_wren    = 1'b0;
      ram_address = 15'd0;
      ram_data    = 3'b000;
      running     = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = CLEAR;
         end
         CLEAR: begin
            ram_wren    = 1'b1;
            ram_address = {scan_x, scan_y};
            if (scan_last) state_nxt = RUN;
         end
         RUN: begin
            running = 1'b1;
            if (tick_go) state_nxt = (tick_cnt == '0) ? TALLY : PAINT_P1;
         end
         PAINT_P1: begin
            running     = 1'b1;
            ram_wren    = 1'b1;
            ram_address = p1;
            ram_data    = 3'b001;
            state_nxt   = PAINT_P2;
         end
         PAINT_P2: begin
            running     = 1'b1;
            ram_wren    = 1'b1;
            ram_address = p2;
            ram_data    = 3'b010;
            state_nxt   = PAINT_P3;
         end
         PAINT_P3: begin
            running     = 1'b1;
            ram_wren    = 1'b1;
            ram_address = p3;
            ram_data    = 3'b100;
            state_nxt   = PAINT_P4;
         end
         PAINT_P4: begin
            running     = 1'b1;
            ram_wren    = 1'b1;
            ram_address = p4;
            ram_data    = 3'b110;
            state_nxt   = RUN;
         end
         TALLY: begin
            ram_address = {scan_x, scan_y};
            if (scan_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nxt = CLEAR;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ram_q holds the colour of the address issued on the previous cycle
   always_comb begin
      for (int i = 0; i < 4; i++) cnt_nxt[i] = cnt[i];
      case (ram_q)
         3'b001:  cnt_nxt[0] = cnt[0] + COUNT_W'(1);
         3'b010:  cnt_nxt[1] = cnt[1] + COUNT_W'(1);
         3'b100:  cnt_nxt[2] = cnt[2] + COUNT_W'(1);
         3'b110:  cnt_nxt[3] = cnt[3] + COUNT_W'(1);
         default: ;
      endcase
   end

   // strict greater-than keeps the lowest player on a tie
   always_comb begin
      best_cnt = cnt_nxt[0];
      win_nxt  = 2'd0;
      for (int i = 1; i < 4; i++) begin
         if (cnt_nxt[i] > best_cnt) begin
            best_cnt = cnt_nxt[i];
            win_nxt  = 2'(i);
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         scan_x   <= 8'd0;
         scan_y   <= 7'd0;
         tick_cnt <= '0;
         rd_vld   <= 1'b0;
         winner   <= 2'd0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         rd_vld <= (state == TALLY);
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  scan_x <= 8'd0;
                  scan_y <= 7'd0;
               end
            end
            CLEAR, TALLY: begin
               if (scan_last) begin
                  scan_x <= 8'd0;
                  scan_y <= 7'd0;
               end else if (scan_y == Y_LAST) begin
                  scan_x <= scan_x + 8'd1;
                  scan_y <= 7'd0;
               end else begin
                  scan_y <= scan_y + 7'd1;
               end
               if (state == CLEAR && scan_last) tick_cnt <= TICK_W'(GAME_TICKS);
               if (state == TALLY && rd_vld) begin
                  for (int i = 0; i < 4; i++) cnt[i] <= cnt_nxt[i];
               end
            end
            RUN: begin
               if (tick_go) begin
                  if (tick_cnt == '0) begin
                     scan_x <= 8'd0;
                     scan_y <= 7'd0;
                     for (int i = 0; i < 4; i++) cnt[i] <= '0;
                  end else begin
                     tick_cnt <= tick_cnt - TICK_W'(1);
                  end
               end
            end
            DRAIN: begin
               for (int i = 0; i < 4; i++) cnt[i] <= cnt_nxt[i];
               winner <= win_nxt;
            end
            default: ;
         endcase
      end
   end

   assign p1_count = cnt[0];
   assign p2_count = cnt[1];
   assign p3_count = cnt[2];
   assign p4_count = cnt[3];

endmodule

// File: tb/tb_turf_ram_scheduler.sv
// Directed bench for turf_ram_scheduler on a 4x2 arena with a two-tick game and a behavioural 1-cycle-latency RAM.
module tb_turf_ram_scheduler;

   logic        CLOCK_50;
   logic        reset;
   logic        start;
   logic        pause;
   logic        move_tick;
   logic [14:0] p1, p2, p3, p4;
   logic [2:0]  ram_q;
   logic        ram_wren;
   logic [14:0] ram_address;
   logic [2:0]  ram_data;
   logic        running;
   logic        done;
   logic [14:0] p1_count, p2_count, p3_count, p4_count;
   logic [1:0]  winner;

   int vectors;
   int miscompares;

   logic [2:0]  mem [0:32767];
   logic [14:0] arena_addr [8];

   turf_ram_scheduler #(
      .GAME_TICKS(2),
      .X_MAX(3),
      .Y_MAX(1),
      .COUNT_W(15)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .reset(reset),
      .start(start),
`ifdef TURF_PAUSE_EN
      .pause(pause),
`endif
      .move_tick(move_tick),
      .p1(p1),
      .p2(p2),
      .p3(p3),
      .p4(p4),
      .ram_q(ram_q),
      .ram_wren(ram_wren),
      .ram_address(ram_address),
      .ram_data(ram_data),
      .running(running),
      .done(done),
      .p1_count(p1_count),
      .p2_count(p2_count),
      .p3_count(p3_count),
      .p4_count(p4_count),
      .winner(winner)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) begin
      if (ram_wren) mem[ram_address] <= ram_data;
      ram_q <= mem[ram_address];
   end

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_clear(input logic [14:0] held_p1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("clear_counts_hold", p1_count, held_p1);
      for (int i = 0; i < 8; i++) begin
         chk("clear_wren", ram_wren, 1'b1);
         chk("clear_addr", ram_address, arena_addr[i]);
         chk("clear_data", ram_data, 3'b000);
         step();
      end
      chk("run_after_clear", running, 1'b1);
      chk("run_wren", ram_wren, 1'b0);
   endtask

   task automatic paint_tick(input logic [14:0] a1, input logic [14:0] a2,
                             input logic [14:0] a3, input logic [14:0] a4, input logic extra);
      move_tick = 1'b1;
      step();
      move_tick = 1'b0;
      chk("p1_wren", ram_wren, 1'b1);
      chk("p1_addr", ram_address, a1);
      chk("p1_data", ram_data, 3'b001);
      move_tick = extra;
      step();
      move_tick = 1'b0;
      chk("p2_addr", ram_address, a2);
      chk("p2_data", ram_data, 3'b010);
      step();
      chk("p3_addr", ram_address, a3);
      chk("p3_data", ram_data, 3'b100);
      step();
      chk("p4_addr", ram_address, a4);
      chk("p4_data", ram_data, 3'b110);
      chk("p4_running", running, 1'b1);
      step();
      chk("back_run_wren", ram_wren, 1'b0);
      chk("back_run_running", running, 1'b1);
   endtask

   task automatic tally_check(input int e1, input int e2, input int e3, input int e4, input int ew);
      move_tick = 1'b1;
      step();
      move_tick = 1'b0;
      chk("tally_entry_wren", ram_wren, 1'b0);
      chk("tally_entry_running", running, 1'b0);
      chk("tally_entry_addr", ram_address, arena_addr[0]);
      for (int i = 1; i < 8; i++) begin
         step();
         chk("tally_addr", ram_address, arena_addr[i]);
         chk("tally_wren", ram_wren, 1'b0);
      end
      step();
      chk("drain_done_low", done, 1'b0);
      step();
      chk("done_at_9", done, 1'b1);
      chk("p1_count", p1_count, 32'(e1));
      chk("p2_count", p2_count, 32'(e2));
      chk("p3_count", p3_count, 32'(e3));
      chk("p4_count", p4_count, 32'(e4));
      chk("winner", winner, 32'(ew));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      arena_addr  = '{15'h0000, 15'h0001, 15'h0080, 15'h0081,
                      15'h0100, 15'h0101, 15'h0180, 15'h0181};
      for (int i = 0; i < 32768; i++) mem[i] = 3'b111;
      reset     = 1'b1;
      start     = 1'b0;
      pause     = 1'b0;
      move_tick = 1'b0;
      p1 = 15'h0000; p2 = 15'h0000; p3 = 15'h0000; p4 = 15'h0000;
      step();
      step();
      reset = 1'b0;
      chk("rst_wren", ram_wren, 1'b0);
      chk("rst_running", running, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_winner", winner, 2'd0);

      // abandon a game part-way through the clear sweep
      start = 1'b1;
      step();
      start = 1'b0;
      chk("midclr_wren", ram_wren, 1'b1);
      step();
      step();
      chk("midclr_addr", ram_address, 15'h0080);
      reset = 1'b1;
      #1;
      chk("async_rst_wren", ram_wren, 1'b0);
      chk("async_rst_done", done, 1'b0);
      chk("async_rst_running", running, 1'b0);
      chk("async_rst_p1", p1_count, 15'd0);
      chk("async_rst_p4", p4_count, 15'd0);
      chk("async_rst_winner", winner, 2'd0);
      step();
      reset = 1'b0;
      step();
      chk("idle_wren", ram_wren, 1'b0);
      chk("idle_running", running, 1'b0);

      // game 1: one pixel each, tick during paint is dropped
      p1 = 15'h0000; p2 = 15'h0001; p3 = 15'h0080; p4 = 15'h0081;
      run_clear(15'd0);
      step();
      step();
      chk("run_idle_wren", ram_wren, 1'b0);
      chk("run_idle_running", running, 1'b1);
      paint_tick(15'h0000, 15'h0001, 15'h0080, 15'h0081, 1'b1);
      step();
      chk("dropped_tick_wren", ram_wren, 1'b0);
      paint_tick(15'h0000, 15'h0001, 15'h0080, 15'h0081, 1'b0);
      tally_check(1, 1, 1, 1, 0);
      step();
      step();
      chk("done_hold", done, 1'b1);
      chk("done_hold_p3", p3_count, 15'd1);

      // game 2: p2 overwrites p1 at 0x0000, three-way tie goes to p1
      p1 = 15'h0001; p2 = 15'h0000; p3 = 15'h0080; p4 = 15'h0080;
      run_clear(15'd1);
      paint_tick(15'h0001, 15'h0000, 15'h0080, 15'h0080, 1'b0);
      p1 = 15'h0000;
      paint_tick(15'h0000, 15'h0000, 15'h0080, 15'h0080, 1'b0);
      chk("overlap_cell", mem[0], 3'b010);
      tally_check(1, 1, 0, 1, 0);

      // game 3: p3 and p4 tie on two pixels, p3 wins
      p1 = 15'h0000; p2 = 15'h0000; p3 = 15'h0001; p4 = 15'h0000;
      run_clear(15'd1);
`ifdef TURF_PAUSE_EN
      pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         move_tick = 1'b1;
         step();
         move_tick = 1'b0;
         chk("pause_wren", ram_wren, 1'b0);
         chk("pause_running", running, 1'b1);
         step();
      end
      pause = 1'b0;
`endif
      paint_tick(15'h0000, 15'h0000, 15'h0001, 15'h0000, 1'b0);
      p1 = 15'h0080; p2 = 15'h0080; p3 = 15'h0081; p4 = 15'h0080;
      paint_tick(15'h0080, 15'h0080, 15'h0081, 15'h0080, 1'b0);
      tally_check(0, 0, 2, 2, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
